temporizador_mag: RTL

- Consumer end of the magnetron-control interface.
- Receives the set/reset pulses issued by the magnetron control logic and holds the magnetron-on state.
- Runs the microwave's MM:SS BCD countdown while the magnetron is on, and returns timer_done to the control logic.
- Also accepts keypad digit entry to preload cooking time while idle.

---
 rtl/temporizador_pkg.sv | 20 ++
 rtl/contador_bcd_dec.sv | 45 ++++
 rtl/temporizador_mag.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// Shared constants and state encoding for the magnetron timer.
// Only the beep logic, enabled with TEMPORIZADOR_BEEP_EN, uses BEEP_TICKS.
package temporizador_pkg;

  localparam int BCD_W        = 4;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int BEEP_TICKS   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(SEC_ONES_MAX);
  endfunction

endpackage

// File: rtl/contador_bcd_dec.sv
// Single BCD decade down-counter with parallel load and a borrow chain.
// A value above max (accepted from the keypad) is clamped to max on its next borrow.
module contador_bcd_dec
  import temporizador_pkg::*;
(
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             borrow_in_i,
  input  logic [BCD_W-1:0] max_i,
  input  logic             load_en_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] q_o,
  output logic             borrow_out_o
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_en_i) begin
      q_d = load_val_i;
    end else if (en_i && borrow_in_i) begin
      if (q_q == '0) begin
        q_d = max_i;
      end else if (q_q > max_i) begin
        q_d = max_i;
      end else begin
        q_d = q_q - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o          = q_q;
  assign borrow_out_o = (q_q == '0) && borrow_in_i;

endmodule

// File: rtl/temporizador_mag.sv
// Magnetron on/off holder with MM:SS BCD countdown and keypad preload.
// Optional beep after natural expiry: define TEMPORIZADOR_BEEP_EN.
//
// state | meaning
// IDLE  | magnetron off; keypad load and clear accepted
// RUN   | magnetron on; count decrements once per second
module temporizador_mag
  import temporizador_pkg::*;
#(
  parameter int CLK_HZ       = 100,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             set_i,
  input  logic             reset_i,
  input  logic             clearn_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] digit_i,
  output logic             mag_on_o,
  output logic             timer_done_o,
  output logic [BCD_W-1:0] min_tens_o,
  output logic [BCD_W-1:0] min_ones_o,
  output logic [BCD_W-1:0] sec_tens_o,
  output logic [BCD_W-1:0] sec_ones_o
`ifdef TEMPORIZADOR_BEEP_EN
  ,
  output logic             beep_o
`endif
);

  localparam int                 PRESC_W    = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 timer_done_q, timer_done_d;

  logic                 tick, dec, cur_zero, at_one, reach_zero;
  logic                 load_ok, load_en;
  logic [BCD_W-1:0]     lv_mt, lv_mo, lv_st, lv_so;
  logic                 so_b, st_b, mo_b, mt_b;

  always_comb begin
    load_ok    = load_i && is_bcd(digit_i);
    load_en    = (state_q == IDLE) && (!clearn_i || load_ok);
    tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
    // The borrow chain is fed with a constant 1, so mt_b means all digits are zero.
    cur_zero   = mt_b;
    dec        = tick && !cur_zero;
    at_one     = (min_tens_o == '0) && (min_ones_o == '0) &&
                 (sec_tens_o == '0) && (sec_ones_o == BCD_W'(1));
    reach_zero = dec && at_one;

    lv_mt = clearn_i ? min_ones_o : '0;
    lv_mo = clearn_i ? sec_tens_o : '0;
    lv_st = clearn_i ? sec_ones_o : '0;
    lv_so = clearn_i ? digit_i    : '0;

    if (load_en) begin
      timer_done_d = ({lv_mt, lv_mo, lv_st, lv_so} == '0);
    end else begin
      timer_done_d = reach_zero || cur_zero;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (set_i && !reset_i && !timer_done_q) state_d = RUN;
      RUN:  if (reset_i || reach_zero || timer_done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef TEMPORIZADOR_BEEP_EN
  logic       beep_q, beep_d;
  logic [1:0] beep_cnt_q, beep_cnt_d;
  logic       beep_tick;

  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    beep_tick  = beep_q && (state_q == IDLE) && (presc_q == PRESC_LAST);
    if (reach_zero) begin
      beep_d     = 1'b1;
      beep_cnt_d = 2'(BEEP_TICKS);
    end else if (!clearn_i || set_i) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (beep_tick) begin
      beep_cnt_d = beep_cnt_q - 2'd1;
      if (beep_cnt_q == 2'd1) beep_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep_o = beep_q;
`endif

  always_comb begin
    presc_d = presc_q;
    if ((state_q == IDLE) && (state_d == RUN)) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
`ifdef TEMPORIZADOR_BEEP_EN
    end else if (beep_q) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      timer_done_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      timer_done_q <= timer_done_d;
    end
  end

  contador_bcd_dec u_sec_ones (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (dec),
    .borrow_in_i (1'b1),
    .max_i       (BCD_W'(SEC_ONES_MAX)),
    .load_en_i   (load_en),
    .load_val_i  (lv_so),
    .q_o         (sec_ones_o),
    .borrow_out_o(so_b)
  );

  contador_bcd_dec u_sec_tens (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (dec),
    .borrow_in_i (so_b),
    .max_i       (BCD_W'(SEC_TENS_MAX)),
    .load_en_i   (load_en),
    .load_val_i  (lv_st),
    .q_o         (sec_tens_o),
    .borrow_out_o(st_b)
  );

  contador_bcd_dec u_min_ones (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (dec),
    .borrow_in_i (st_b),
    .max_i       (BCD_W'(MIN_ONES_MAX)),
    .load_en_i   (load_en),
    .load_val_i  (lv_mo),
    .q_o         (min_ones_o),
    .borrow_out_o(mo_b)
  );

  contador_bcd_dec u_min_tens (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (dec),
    .borrow_in_i (mo_b),
    .max_i       (BCD_W'(MAX_MIN_TENS)),
    .load_en_i   (load_en),
    .load_val_i  (lv_mt),
    .q_o         (min_tens_o),
    .borrow_out_o(mt_b)
  );

  assign mag_on_o     = (state_q == RUN);
  assign timer_done_o = timer_done_q;

endmodule
